ctrl_pipe: RTL and testbench

- Next-generation control unit for the pipelined RV32 core.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards, inserts bubbles on hazard, flush or illegal opcode, and supports a global freeze.
- Adds optional jal/lui decode and a saturating stall counter; replaces the purely combinational decoder.

---
 rtl/ctrl_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control unit for the pipelined RV32 core.
// Decodes the ID-stage opcode into a control bundle, carries it through the
// ID/EX, EX/MEM and MEM/WB stage registers, raises a load-use stall request,
// squashes the ID slot on hazard/flush/illegal opcode, honours a global freeze
// and counts stall cycles in a saturating counter.
module ctrl_pipe #(
  parameter int REG_AW  = 5,
  parameter bit EXT_OPS = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [6:0]        Op_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hazard_stall_o,
  output logic [1:0]        ALUOp_ex_o,
  output logic              ALUSrc_ex_o,
  output logic              Jump_ex_o,
  output logic              Lui_ex_o,
  output logic              illegal_ex_o,
  output logic [REG_AW-1:0] rd_ex_o,
  output logic              MemRead_mem_o,
  output logic              MemWrite_mem_o,
  output logic              RegWrite_mem_o,
  output logic [REG_AW-1:0] rd_mem_o,
  output logic              RegWrite_wb_o,
  output logic [1:0]        WbSel_wb_o,
  output logic [REG_AW-1:0] rd_wb_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Full bundle held in ID/EX; an all-zero value is a bubble.
  typedef struct packed {
    logic [1:0]        aluOp;
    logic              aluSrc;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic [1:0]        wbSel;
    logic              jump;
    logic              lui;
    logic              illegal;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic [1:0]        wbSel;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              regWrite;
    logic [1:0]        wbSel;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  idex_t             dec;
  logic              useRs1;
  logic              useRs2;
  logic              regWriteRaw;
  logic              hazard;

  idex_t             idex_q,  idex_d;
  exmem_t            exmem_q, exmem_d;
  memwb_t            memwb_q, memwb_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Decode the ID-stage opcode; rd is only kept by instructions that write a register.
  always_comb begin
    dec         = '0;
    useRs1      = 1'b0;
    useRs2      = 1'b0;
    regWriteRaw = 1'b0;
    if (valid_i) begin
      case (Op_i)
        OP_R: begin
          dec.aluOp   = 2'b10;
          regWriteRaw = 1'b1;
          dec.rd      = rd_i;
          useRs1      = 1'b1;
          useRs2      = 1'b1;
        end
        OP_I: begin
          dec.aluOp   = 2'b11;
          dec.aluSrc  = 1'b1;
          regWriteRaw = 1'b1;
          dec.rd      = rd_i;
          useRs1      = 1'b1;
        end
        OP_LW: begin
          dec.aluSrc  = 1'b1;
          regWriteRaw = 1'b1;
          dec.memRead = 1'b1;
          dec.wbSel   = WB_MEM;
          dec.rd      = rd_i;
          useRs1      = 1'b1;
        end
        OP_SW: begin
          dec.aluSrc   = 1'b1;
          dec.memWrite = 1'b1;
          useRs1       = 1'b1;
          useRs2       = 1'b1;
        end
        OP_BEQ: begin
          dec.aluOp = 2'b01;
          useRs1    = 1'b1;
          useRs2    = 1'b1;
        end
        OP_JAL: begin
          if (EXT_OPS) begin
            dec.aluSrc  = 1'b1;
            regWriteRaw = 1'b1;
            dec.wbSel   = WB_PC4;
            dec.jump    = 1'b1;
            dec.rd      = rd_i;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_LUI: begin
          if (EXT_OPS) begin
            dec.aluSrc  = 1'b1;
            regWriteRaw = 1'b1;
            dec.wbSel   = WB_ALU;
            dec.lui     = 1'b1;
            dec.rd      = rd_i;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_NOP: begin
          dec.illegal = 1'b0;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
    dec.regWrite = regWriteRaw & (|dec.rd);
  end

  // Load-use check: a load in EX whose destination feeds a source the ID instruction reads.
  always_comb begin
    hazard = valid_i & idex_q.memRead & (|idex_q.rd) &
             (((idex_q.rd == rs1_i) & useRs1) | ((idex_q.rd == rs2_i) & useRs2));
  end

  // Next-state for stage registers and the saturating stall counter; freeze wins over squash.
  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    cnt_d   = cnt_q;
    if ((stall_i | hazard) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (!stall_i) begin
      memwb_d.regWrite = exmem_q.regWrite;
      memwb_d.wbSel    = exmem_q.wbSel;
      memwb_d.rd       = exmem_q.rd;
      exmem_d.regWrite = idex_q.regWrite;
      exmem_d.memRead  = idex_q.memRead;
      exmem_d.memWrite = idex_q.memWrite;
      exmem_d.wbSel    = idex_q.wbSel;
      exmem_d.rd       = idex_q.rd;
      idex_d           = (flush_i | hazard) ? '0 : dec;
    end
  end

  // Stage registers and counter; reset discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive the per-stage outputs straight from the stage registers.
  always_comb begin
    hazard_stall_o = hazard;
    ALUOp_ex_o     = idex_q.aluOp;
    ALUSrc_ex_o    = idex_q.aluSrc;
    Jump_ex_o      = idex_q.jump;
    Lui_ex_o       = idex_q.lui;
    illegal_ex_o   = idex_q.illegal;
    rd_ex_o        = idex_q.rd;
    MemRead_mem_o  = exmem_q.memRead;
    MemWrite_mem_o = exmem_q.memWrite;
    RegWrite_mem_o = exmem_q.regWrite;
    rd_mem_o       = exmem_q.rd;
    RegWrite_wb_o  = memwb_q.regWrite;
    WbSel_wb_o     = memwb_q.wbSel;
    rd_wb_o        = memwb_q.rd;
    stall_cnt_o    = cnt_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: three ctrl_pipe instances share one stimulus stream.
// u0: EXT_OPS=1, CNT_W=16; u1: EXT_OPS=0, CNT_W=16; u2: EXT_OPS=1, CNT_W=2.
// A behavioural pipeline model (decode table + three-slot array) predicts
// every output each cycle; directed sequences add literal expectations.
module tb_ctrl_pipe;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] wbSel;
    logic       jump;
    logic       lui;
    logic       illegal;
    logic [4:0] rd;
    logic       useRs1;
    logic       useRs2;
  } bundle_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [6:0] op = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic       hazO [3];
  logic [1:0] aluOpEx [3];
  logic       aluSrcEx [3];
  logic       jumpEx [3];
  logic       luiEx [3];
  logic       illEx [3];
  logic [4:0] rdEx [3];
  logic       memReadMem [3];
  logic       memWriteMem [3];
  logic       regWriteMem [3];
  logic [4:0] rdMem [3];
  logic       regWriteWb [3];
  logic [1:0] wbSelWb [3];
  logic [4:0] rdWb [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // Model state: pipe[inst][0]=EX, [1]=MEM, [2]=WB.
  bundle_t     pipe [3][3];
  int unsigned cntM [3];
  bit          modelValid = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(5), .EXT_OPS(1'b1), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .stall_i(stall), .flush_i(flush), .hazard_stall_o(hazO[0]), .ALUOp_ex_o(aluOpEx[0]),
    .ALUSrc_ex_o(aluSrcEx[0]), .Jump_ex_o(jumpEx[0]), .Lui_ex_o(luiEx[0]), .illegal_ex_o(illEx[0]),
    .rd_ex_o(rdEx[0]), .MemRead_mem_o(memReadMem[0]), .MemWrite_mem_o(memWriteMem[0]),
    .RegWrite_mem_o(regWriteMem[0]), .rd_mem_o(rdMem[0]), .RegWrite_wb_o(regWriteWb[0]),
    .WbSel_wb_o(wbSelWb[0]), .rd_wb_o(rdWb[0]), .stall_cnt_o(cnt0));

  ctrl_pipe #(.REG_AW(5), .EXT_OPS(1'b0), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .stall_i(stall), .flush_i(flush), .hazard_stall_o(hazO[1]), .ALUOp_ex_o(aluOpEx[1]),
    .ALUSrc_ex_o(aluSrcEx[1]), .Jump_ex_o(jumpEx[1]), .Lui_ex_o(luiEx[1]), .illegal_ex_o(illEx[1]),
    .rd_ex_o(rdEx[1]), .MemRead_mem_o(memReadMem[1]), .MemWrite_mem_o(memWriteMem[1]),
    .RegWrite_mem_o(regWriteMem[1]), .rd_mem_o(rdMem[1]), .RegWrite_wb_o(regWriteWb[1]),
    .WbSel_wb_o(wbSelWb[1]), .rd_wb_o(rdWb[1]), .stall_cnt_o(cnt1));

  ctrl_pipe #(.REG_AW(5), .EXT_OPS(1'b1), .CNT_W(2)) u2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .stall_i(stall), .flush_i(flush), .hazard_stall_o(hazO[2]), .ALUOp_ex_o(aluOpEx[2]),
    .ALUSrc_ex_o(aluSrcEx[2]), .Jump_ex_o(jumpEx[2]), .Lui_ex_o(luiEx[2]), .illegal_ex_o(illEx[2]),
    .rd_ex_o(rdEx[2]), .MemRead_mem_o(memReadMem[2]), .MemWrite_mem_o(memWriteMem[2]),
    .RegWrite_mem_o(regWriteMem[2]), .rd_mem_o(rdMem[2]), .RegWrite_wb_o(regWriteWb[2]),
    .WbSel_wb_o(wbSelWb[2]), .rd_wb_o(rdWb[2]), .stall_cnt_o(cnt2));

  function automatic bit extOf(int inst);
    return (inst != 1);
  endfunction

  function automatic int unsigned cntMaxOf(int inst);
    return (inst == 2) ? 32'd3 : 32'd65535;
  endfunction

  // Decode table: what each opcode means as a control bundle.
  function automatic bundle_t decodeRef(bit v, logic [6:0] o, logic [4:0] d, bit ext);
    bundle_t b;
    b = '0;
    if (!v) return b;
    case (o)
      7'b0110011: begin b.aluOp = 2'b10; b.regWrite = 1; b.rd = d; b.useRs1 = 1; b.useRs2 = 1; end
      7'b0010011: begin b.aluOp = 2'b11; b.aluSrc = 1; b.regWrite = 1; b.rd = d; b.useRs1 = 1; end
      7'b0000011: begin b.aluSrc = 1; b.regWrite = 1; b.memRead = 1; b.wbSel = 2'b01; b.rd = d; b.useRs1 = 1; end
      7'b0100011: begin b.aluSrc = 1; b.memWrite = 1; b.useRs1 = 1; b.useRs2 = 1; end
      7'b1100011: begin b.aluOp = 2'b01; b.useRs1 = 1; b.useRs2 = 1; end
      7'b1101111: if (ext) begin b.aluSrc = 1; b.regWrite = 1; b.wbSel = 2'b10; b.jump = 1; b.rd = d; end
                  else b.illegal = 1;
      7'b0110111: if (ext) begin b.aluSrc = 1; b.regWrite = 1; b.lui = 1; b.rd = d; end
                  else b.illegal = 1;
      7'b0000000: b.illegal = 0;
      default:    b.illegal = 1;
    endcase
    if (b.rd == 5'd0) b.regWrite = 0;
    return b;
  endfunction

  function automatic bit hazardRef(int inst);
    bundle_t d;
    bundle_t ex;
    d  = decodeRef(valid, op, rd, extOf(inst));
    ex = pipe[inst][0];
    return valid && ex.memRead && (ex.rd != 0) &&
           (((ex.rd == rs1) && d.useRs1) || ((ex.rd == rs2) && d.useRs2));
  endfunction

  task automatic checkOutput(input string name, input int inst, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s u%0d at %0t: got %0d expected %0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [6:0] o, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] d, input bit s, input bit f);
    @(posedge clk);
    #1;
    rst = r; valid = v; op = o; rs1 = a; rs2 = b; rd = d; stall = s; flush = f;
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 7'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic bubble();
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model on each clock edge using the pre-edge state.
  always @(posedge clk) begin
    bit haz;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int s = 0; s < 3; s++) pipe[i][s] = '0;
        cntM[i] = 0;
      end
      modelValid = 1'b1;
    end else if (modelValid) begin
      for (int i = 0; i < 3; i++) begin
        haz = hazardRef(i);
        if ((stall || haz) && cntM[i] < cntMaxOf(i)) cntM[i]++;
        if (!stall) begin
          pipe[i][2] = pipe[i][1];
          pipe[i][1] = pipe[i][0];
          pipe[i][0] = (flush || haz) ? '0 : decodeRef(valid, op, rd, extOf(i));
        end
      end
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    int unsigned cAct;
    if (modelValid) begin
      for (int i = 0; i < 3; i++) begin
        cAct = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
        checkOutput("hazard", i, hazO[i], hazardRef(i));
        checkOutput("ALUOp_ex", i, aluOpEx[i], pipe[i][0].aluOp);
        checkOutput("ALUSrc_ex", i, aluSrcEx[i], pipe[i][0].aluSrc);
        checkOutput("Jump_ex", i, jumpEx[i], pipe[i][0].jump);
        checkOutput("Lui_ex", i, luiEx[i], pipe[i][0].lui);
        checkOutput("illegal_ex", i, illEx[i], pipe[i][0].illegal);
        checkOutput("rd_ex", i, rdEx[i], pipe[i][0].rd);
        checkOutput("MemRead_mem", i, memReadMem[i], pipe[i][1].memRead);
        checkOutput("MemWrite_mem", i, memWriteMem[i], pipe[i][1].memWrite);
        checkOutput("RegWrite_mem", i, regWriteMem[i], pipe[i][1].regWrite);
        checkOutput("rd_mem", i, rdMem[i], pipe[i][1].rd);
        checkOutput("RegWrite_wb", i, regWriteWb[i], pipe[i][2].regWrite);
        checkOutput("WbSel_wb", i, wbSelWb[i], pipe[i][2].wbSel);
        checkOutput("rd_wb", i, rdWb[i], pipe[i][2].rd);
        checkOutput("stall_cnt", i, cAct, cntM[i]);
      end
    end
  end

  logic [6:0] seqOp  [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  logic [4:0] seqRd  [5] = '{5'd3, 5'd4, 5'd5, 5'd9, 5'd9};
  logic [4:0] seqRs1 [5] = '{5'd1, 5'd3, 5'd1, 5'd1, 5'd1};
  logic       expRw  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] expSel [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
  logic [4:0] expRd  [5] = '{5'd3, 5'd4, 5'd5, 5'd0, 5'd0};
  logic [6:0] opPool [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};

  initial begin
    // Reset state.
    doReset();
    bubble();
    @(negedge clk);
    checkOutput("lit_reset_rd_wb", 0, rdWb[0], 0);
    checkOutput("lit_reset_cnt", 0, cnt0, 0);
    checkOutput("lit_reset_hazard", 0, hazO[0], 0);

    // add x3 / addi x4 / lw x5 / sw / beq reach WB three cycles after decode.
    doReset();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) applyStimulus(0, 1, seqOp[i], seqRs1[i], 5'd2, seqRd[i], 0, 0);
      else bubble();
      @(negedge clk);
      if (i >= 3) begin
        checkOutput("lit_seq_RegWrite_wb", 0, regWriteWb[0], expRw[i-3]);
        checkOutput("lit_seq_WbSel_wb", 0, wbSelWb[0], expSel[i-3]);
        checkOutput("lit_seq_rd_wb", 0, rdWb[0], expRd[i-3]);
      end
    end

    // lw x5 then add x6,x5,x1: one stall cycle, bubble then add in EX.
    doReset();
    applyStimulus(0, 1, 7'b0000011, 5'd1, 5'd0, 5'd5, 0, 0);
    applyStimulus(0, 1, 7'b0110011, 5'd5, 5'd1, 5'd6, 0, 0);
    @(negedge clk);
    checkOutput("lit_lu_hazard_on", 0, hazO[0], 1);
    applyStimulus(0, 1, 7'b0110011, 5'd5, 5'd1, 5'd6, 0, 0);
    @(negedge clk);
    checkOutput("lit_lu_hazard_off", 0, hazO[0], 0);
    checkOutput("lit_lu_bubble_rd_ex", 0, rdEx[0], 0);
    checkOutput("lit_lu_cnt", 0, cnt0, 1);
    bubble();
    @(negedge clk);
    checkOutput("lit_lu_add_ALUOp", 0, aluOpEx[0], 2);
    checkOutput("lit_lu_add_rd_ex", 0, rdEx[0], 6);

    // lw x5 then addi x6,x7 with rs2 field 5: no hazard.
    doReset();
    applyStimulus(0, 1, 7'b0000011, 5'd1, 5'd0, 5'd5, 0, 0);
    applyStimulus(0, 1, 7'b0010011, 5'd7, 5'd5, 5'd6, 0, 0);
    @(negedge clk);
    checkOutput("lit_addi_rs2_no_hazard", 0, hazO[0], 0);

    // lw x0 then add using x0: no hazard.
    doReset();
    applyStimulus(0, 1, 7'b0000011, 5'd1, 5'd0, 5'd0, 0, 0);
    applyStimulus(0, 1, 7'b0110011, 5'd0, 5'd0, 5'd7, 0, 0);
    @(negedge clk);
    checkOutput("lit_x0_no_hazard", 0, hazO[0], 0);

    // Illegal opcode pulses once; flushed illegal does not.
    doReset();
    applyStimulus(0, 1, 7'b1111111, 5'd1, 5'd2, 5'd7, 0, 0);
    bubble();
    @(negedge clk);
    checkOutput("lit_illegal_pulse", 0, illEx[0], 1);
    bubble();
    @(negedge clk);
    checkOutput("lit_illegal_clear", 0, illEx[0], 0);
    bubble();
    @(negedge clk);
    checkOutput("lit_illegal_no_wb", 0, regWriteWb[0], 0);
    applyStimulus(0, 1, 7'b1111111, 5'd1, 5'd2, 5'd7, 0, 1);
    bubble();
    @(negedge clk);
    checkOutput("lit_illegal_flushed", 0, illEx[0], 0);

    // jal x1: decoded with EXT_OPS=1, illegal with EXT_OPS=0.
    doReset();
    applyStimulus(0, 1, 7'b1101111, 5'd0, 5'd0, 5'd1, 0, 0);
    bubble();
    @(negedge clk);
    checkOutput("lit_jal_jump_ex", 0, jumpEx[0], 1);
    checkOutput("lit_jal_noext_illegal", 1, illEx[1], 1);
    bubble();
    bubble();
    @(negedge clk);
    checkOutput("lit_jal_WbSel_wb", 0, wbSelWb[0], 2);
    checkOutput("lit_jal_rd_wb", 0, rdWb[0], 1);
    checkOutput("lit_jal_noext_RegWrite_wb", 1, regWriteWb[1], 0);

    // Freeze for 3 cycles during a lw, flush in the middle cycle is ignored.
    doReset();
    applyStimulus(0, 1, 7'b0000011, 5'd1, 5'd0, 5'd5, 0, 0);
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lit_frz1_rd_ex", 0, rdEx[0], 5);
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("lit_frz2_rd_ex", 0, rdEx[0], 5);
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lit_frz3_rd_ex", 0, rdEx[0], 5);
    bubble();
    @(negedge clk);
    checkOutput("lit_frz_after_rd_ex", 0, rdEx[0], 5);
    checkOutput("lit_frz_cnt", 0, cnt0, 3);
    bubble();
    @(negedge clk);
    checkOutput("lit_frz_MemRead_mem", 0, memReadMem[0], 1);

    // Saturation: five stall cycles leave the 2-bit counter at 3.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 7'd0, 0, 0, 0, 1, 0);
    bubble();
    @(negedge clk);
    checkOutput("lit_sat_cnt2", 2, cnt2, 3);
    checkOutput("lit_sat_cnt16", 0, cnt0, 5);

    // Reset while frozen clears everything.
    doReset();
    applyStimulus(0, 1, 7'b0000011, 5'd1, 5'd0, 5'd5, 0, 0);
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 7'd0, 0, 0, 0, 1, 0);
    bubble();
    @(negedge clk);
    checkOutput("lit_rstfrz_rd_ex", 0, rdEx[0], 0);
    checkOutput("lit_rstfrz_cnt", 0, cnt0, 0);
    checkOutput("lit_rstfrz_ALUSrc", 0, aluSrcEx[0], 0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int k;
      logic [6:0] o;
      k = $urandom_range(0, 9);
      if (k == 9) o = 7'($urandom_range(0, 127));
      else o = opPool[k];
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, o,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    bubble();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
